esc_pwm_driver: RTL and testbench
=================================

// Module: esc_pwm_driver
// PURPOSE
//  Consumes the 8-bit duty value (0..100 = 0%..100%) from the motor offset summer and drives one ESC PWM line.
//  Adds an ESC arming sequence after enable, saturating clamp, and period-synchronous (glitch-free) duty update.
//  One instance per motor; period_start lets upstream logic align its updates to PWM frames.
// PARAMETERS
//  PRESCALE     500    clk cycles per duty step (>=1); period = DUTY_MAX*PRESCALE clk cycles
//  DUTY_MAX     100    steps per period; also the clamp ceiling for duty_in (1..255)
//  ARM_DUTY     8'h32  duty held during arming (50%, ESC idle level); must be <= DUTY_MAX
//  ARM_PERIODS  250    number of full periods spent in ARMING before RUN (>=1)
// PORTS
//  clk           in   1  system clock
//  rst_n         in   1  asynchronous active-low reset
//  enable        in   1  1 = drive motor; 0 = force output low, disarm
//  duty_in       in   8  requested duty 0..DUTY_MAX (values above are clamped)
//  pwm_out       out  1  PWM to ESC
//  period_start  out  1  1-cycle pulse in the first clk cycle of every period
//  armed         out  1  1 while in RUN state
//  duty_active   out  8  duty currently being generated (latched at period start)
//  duty_clamped  out  1  1 for the whole period if duty_in exceeded DUTY_MAX when latched
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=IDLE; presc_cnt, step_cnt, arm_cnt, duty_active=0;
//    pwm_out, period_start, armed, duty_clamped=0.
//  - Counters: presc_cnt 0..PRESCALE-1; tick = (presc_cnt==PRESCALE-1). step_cnt 0..DUTY_MAX-1, advances on tick.
//    Period end (pe) = tick && step_cnt==DUTY_MAX-1; at pe both counters wrap to 0.
//  - pwm_out = (state!=IDLE) && (step_cnt < duty_active), decoded only from registers (no input path).
//    High time = duty_active*PRESCALE clk cycles exactly; duty 0 -> constant low; DUTY_MAX -> constant high.
//  - States:
//    IDLE: counters held at 0, pwm_out=0. enable=1 -> ARMING; on that edge duty_active<=ARM_DUTY,
//      arm_cnt<=0, duty_clamped<=0, period_start<=1.
//    ARMING: at pe: if arm_cnt==ARM_PERIODS-1 -> RUN, armed<=1, duty_active<=clamp(duty_in);
//      else arm_cnt<=arm_cnt+1, duty_active<=ARM_DUTY. duty_in ignored until the RUN transition.
//    RUN: at pe duty_active<=clamp(duty_in), duty_clamped<=(duty_in>DUTY_MAX).
//    Any state, enable=0 -> IDLE on next edge: counters, arm_cnt cleared, armed=0, duty_active=0,
//      duty_clamped=0, pwm_out low from that cycle (current period aborted, not completed).
//  - period_start registered: 1 in the cycle after IDLE->ARMING edge and the cycle after every pe edge, else 0.
//  - duty_in sampled only on pe edges; mid-period changes never alter the running period.
//  - clamp(x) = (x > DUTY_MAX) ? DUTY_MAX : x, unsigned 8-bit compare.
//  - enable falling and pe on same edge: enable wins (IDLE, no latch).
//  - Re-enable after disarm always repeats the full ARM_PERIODS sequence.
// TESTING (bench params PRESCALE=4, DUTY_MAX=100, ARM_DUTY=50, ARM_PERIODS=2)
//  1. Reset asserted, enable=1, duty_in=8'h40 -> pwm_out, armed, period_start, duty_active all 0 while rst_n=0.
//  2. enable=1, duty_in=75 -> two 400-cycle periods with 200-cycle high; armed=1 at 3rd period start;
//     then 300-cycle high per period; period_start every 400 cycles.
//  3. RUN, duty_in=8'hC8 -> next period duty_active=100, pwm_out high all 400 cycles, duty_clamped=1;
//     duty_in=0 -> following period pwm_out constant low, duty_clamped=0.
//  4. RUN, duty_in 30 -> 70 at cycle 50 of a period -> that period high 120 cycles, next period high 280.
//  5. enable dropped at cycle 100 of a RUN period -> pwm_out=0, armed=0 next cycle; re-enable ->
//     two 50% arming periods again before RUN.
//  6. rst_n pulsed low mid-high-time -> pwm_out 0 immediately (asynchronous, no clock edge); restart as test 2.

Source files
------------

// File: rtl/esc_pwm_driver.sv
// ESC PWM driver: arming sequence after enable, clamped duty latched once per
// period so the waveform never glitches mid-frame.
module esc_pwm_driver #(
  parameter int         PRESCALE    = 500,
  parameter int         DUTY_MAX    = 100,
  parameter logic [7:0] ARM_DUTY    = 8'h32,
  parameter int         ARM_PERIODS = 250
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [7:0] duty_in,
  output logic       pwm_out,
  output logic       period_start,
  output logic       armed,
  output logic [7:0] duty_active,
  output logic       duty_clamped,
  output logic [1:0] state_o
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int AW = (ARM_PERIODS > 1) ? $clog2(ARM_PERIODS) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);
  localparam logic [7:0]    STEP_LAST  = 8'(DUTY_MAX - 1);
  localparam logic [7:0]    DMAX       = 8'(DUTY_MAX);
  localparam logic [AW-1:0] ARM_LAST   = AW'(ARM_PERIODS - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, ARMING = 2'd1, RUN = 2'd2} state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [7:0]    step_q, step_d;
  logic [AW-1:0] arm_q, arm_d;
  logic [7:0]    duty_q, duty_d;
  logic          clamped_q, clamped_d;
  logic          armed_q, armed_d;
  logic          pstart_q, pstart_d;

  logic       tick, pe, over;
  logic [7:0] duty_sat;

  assign tick     = (presc_q == PRESC_LAST);
  assign pe       = tick && (step_q == STEP_LAST);
  assign over     = (duty_in > DMAX);
  assign duty_sat = over ? DMAX : duty_in;

  always_comb begin
    state_d   = state_q;
    presc_d   = presc_q;
    step_d    = step_q;
    arm_d     = arm_q;
    duty_d    = duty_q;
    clamped_d = clamped_q;
    armed_d   = armed_q;
    pstart_d  = 1'b0;
    case (state_q)
      IDLE: begin
        presc_d = '0;
        step_d  = '0;
        if (enable) begin
          state_d   = ARMING;
          duty_d    = ARM_DUTY;
          arm_d     = '0;
          clamped_d = 1'b0;
          pstart_d  = 1'b1;
        end
      end
      ARMING, RUN: begin
        if (tick) begin
          presc_d = '0;
          step_d  = (step_q == STEP_LAST) ? 8'd0 : step_q + 8'd1;
        end else begin
          presc_d = presc_q + PW'(1);
        end
        if (pe) begin
          pstart_d = 1'b1;
          if (state_q == ARMING) begin
            if (arm_q == ARM_LAST) begin
              state_d = RUN;
              armed_d = 1'b1;
              duty_d  = duty_sat;
            end else begin
              arm_d  = arm_q + AW'(1);
              duty_d = ARM_DUTY;
            end
          end else begin
            duty_d    = duty_sat;
            clamped_d = over;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // Disable overrides everything, including a coincident period end.
    if (!enable) begin
      state_d   = IDLE;
      presc_d   = '0;
      step_d    = '0;
      arm_d     = '0;
      duty_d    = '0;
      clamped_d = 1'b0;
      armed_d   = 1'b0;
      pstart_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      presc_q   <= '0;
      step_q    <= '0;
      arm_q     <= '0;
      duty_q    <= '0;
      clamped_q <= 1'b0;
      armed_q   <= 1'b0;
      pstart_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      step_q    <= step_d;
      arm_q     <= arm_d;
      duty_q    <= duty_d;
      clamped_q <= clamped_d;
      armed_q   <= armed_d;
      pstart_q  <= pstart_d;
    end
  end

  // Decoded from registers only, so reset drops the line without a clock edge.
  assign pwm_out      = (state_q != IDLE) && (step_q < duty_q);
  assign period_start = pstart_q;
  assign armed        = armed_q;
  assign duty_active  = duty_q;
  assign duty_clamped = clamped_q;
  assign state_o      = state_q;

endmodule

// File: tb/tb_esc_pwm_driver.sv
// Bench for esc_pwm_driver: frame-position reference model, per-cycle output
// checks and a per-period high-time scoreboard.
module tb_esc_pwm_driver;

  localparam int PRESCALE    = 4;
  localparam int DUTY_MAX    = 100;
  localparam int ARM_DUTY    = 50;
  localparam int ARM_PERIODS = 2;
  localparam int PERIOD      = DUTY_MAX * PRESCALE;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic [7:0] duty_in = 8'h00;
  logic       pwm_out, period_start, armed, duty_clamped;
  logic [7:0] duty_active;
  logic [1:0] state_o;

  int n_cmp = 0;
  int n_err = 0;

  esc_pwm_driver #(
    .PRESCALE(PRESCALE), .DUTY_MAX(DUTY_MAX),
    .ARM_DUTY(8'(ARM_DUTY)), .ARM_PERIODS(ARM_PERIODS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .duty_in(duty_in),
    .pwm_out(pwm_out), .period_start(period_start), .armed(armed),
    .duty_active(duty_active), .duty_clamped(duty_clamped), .state_o(state_o)
  );

  // clock
  always #5 clk = ~clk;

  // reference model: position within the current frame plus the frame's duty
  bit m_on, m_armed, m_clamped, m_pstart;
  int m_pos, m_duty, m_periods;

  function automatic int clamp(input int x);
    return (x > DUTY_MAX) ? DUTY_MAX : x;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n || !enable) begin
      m_on = 0; m_armed = 0; m_clamped = 0; m_pstart = 0;
      m_pos = 0; m_duty = 0; m_periods = 0;
    end else if (!m_on) begin
      m_on = 1; m_pos = 0; m_duty = ARM_DUTY; m_periods = 0;
      m_clamped = 0; m_pstart = 1;
    end else begin
      m_pstart = 0;
      if (m_pos == PERIOD - 1) begin
        m_pos = 0;
        m_pstart = 1;
        m_periods++;
        if (!m_armed) begin
          if (m_periods == ARM_PERIODS) begin
            m_armed = 1;
            m_duty = clamp(int'(duty_in));
          end else begin
            m_duty = ARM_DUTY;
          end
        end else begin
          m_duty = clamp(int'(duty_in));
          m_clamped = (int'(duty_in) > DUTY_MAX);
        end
      end else begin
        m_pos++;
      end
    end
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d at t=%0t", tag, obs, exp, $time);
    end
  endtask

  // scoreboard: expected high time of each frame, compared when it completes
  logic [15:0] exp_q[$];
  bit meas_active = 0;
  int hi_cnt = 0;

  always @(negedge clk) begin
    check("pwm_out", int'(pwm_out), int'(m_on && (m_pos < m_duty * PRESCALE)));
    check("period_start", int'(period_start), int'(m_pstart));
    check("armed", int'(armed), int'(m_armed));
    check("duty_active", int'(duty_active), m_duty);
    check("duty_clamped", int'(duty_clamped), int'(m_clamped));
    if (!m_on) begin
      exp_q.delete();
      meas_active = 0;
      hi_cnt = 0;
    end else if (m_pstart) begin
      if (meas_active && exp_q.size() > 0) check("period_high", hi_cnt, int'(exp_q.pop_front()));
      exp_q.push_back(16'(m_duty * PRESCALE));
      meas_active = 1;
      hi_cnt = 0;
    end
    if (meas_active && pwm_out) hi_cnt++;
  end

  // driver tasks
  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_pstart();
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!period_start && k < 2 * PERIOD);
    check("pstart_timeout", int'(period_start), 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    // reset held with enable and a duty request present
    rst_n = 1'b0; enable = 1'b1; duty_in = 8'h40;
    cycles(5);
    check("rst_pwm", int'(pwm_out), 0);
    check("rst_duty", int'(duty_active), 0);
    rst_n = 1'b1;

    // arming then RUN at 75%
    duty_in = 8'd75;
    cycles((ARM_PERIODS + 2) * PERIOD + 10);
    check("run_armed", int'(armed), 1);

    // saturation, then zero duty
    duty_in = 8'hC8;
    cycles(2 * PERIOD);
    check("sat_duty", int'(duty_active), DUTY_MAX);
    check("sat_flag", int'(duty_clamped), 1);
    duty_in = 8'd0;
    cycles(2 * PERIOD);
    check("zero_duty", int'(duty_active), 0);

    // mid-period duty change only takes effect next frame
    duty_in = 8'd30;
    wait_pstart();
    wait_pstart();
    cycles(49);
    duty_in = 8'd70;
    wait_pstart();
    cycles(PERIOD);

    // random duty requests at random points in the frame, including > DUTY_MAX
    for (int i = 0; i < 10; i++) begin
      cycles($urandom_range(1, PERIOD - 1));
      duty_in = 8'($urandom_range(0, 255));
    end
    cycles(PERIOD);

    // disarm mid-RUN, then full re-arm
    duty_in = 8'd60;
    wait_pstart();
    cycles(100);
    enable = 1'b0;
    cycles(1);
    check("disarm_pwm", int'(pwm_out), 0);
    check("disarm_armed", int'(armed), 0);
    cycles(20);
    enable = 1'b1;
    cycles((ARM_PERIODS + 1) * PERIOD + 10);

    // random enable drops, some landing near a period end
    for (int i = 0; i < 4; i++) begin
      cycles($urandom_range(50, 3 * PERIOD));
      enable = 1'b0;
      cycles($urandom_range(1, 10));
      enable = 1'b1;
    end
    enable = 1'b0;
    cycles(3);
    enable = 1'b1;
    cycles(PERIOD - 1);
    enable = 1'b0;
    cycles(2);
    enable = 1'b1;

    // asynchronous reset during high time
    wait_pstart();
    cycles(10);
    #2 rst_n = 1'b0;
    #1 check("async_rst_pwm", int'(pwm_out), 0);
    cycles(3);
    rst_n = 1'b1;
    duty_in = 8'd75;
    cycles((ARM_PERIODS + 2) * PERIOD + 10);
    check("restart_armed", int'(armed), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
